// File: rtl/mux_8_1_vector_sequencer_pkg.sv
// Shared types and constants for the mux_8_1 vector sequencer slice.
package mux_8_1_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // Feedback taps of the 8-bit data LFSR: bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // first_fail packs {round[7:0], sel[2:0]}.
    localparam int FIRST_FAIL_W = 11;

    // XOR-reduce the tapped bits to form the bit shifted in at the LSB.
    function automatic logic lfsr_feedback(input logic [7:0] x);
        return ^(x & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/mux_8_1_vector_sequencer_if.sv
// Stimulus/score bus between the sequencer and the mux_8_1 fabric plus its run controls.
interface mux_8_1_vector_sequencer_if #(
    parameter int CNT_W = 16
);
    import mux_8_1_seq_pkg::*;

    logic                    start;
    logic [7:0]              d_out;
    logic [2:0]              s_out;
    logic                    mux_out;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        pass_count;
    logic [CNT_W-1:0]        fail_count;
    logic [FIRST_FAIL_W-1:0] first_fail;

    // Sequencer side.
    modport master (
        input  start, mux_out,
        output d_out, s_out, busy, done, pass_count, fail_count, first_fail
    );

    // Fabric / controller side.
    modport slave (
        output start, mux_out,
        input  d_out, s_out, busy, done, pass_count, fail_count, first_fail
    );

endinterface

// File: rtl/mux_8_1_vector_sequencer_lfsr8.sv
// Next data word for the sequencer: 8-bit LFSR step with an all-zero escape.
module mux_8_1_lfsr8
    import mux_8_1_seq_pkg::*;
(
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

    // An all-zero word would lock the LFSR, so it is forced to 8'h01.
    always_comb begin
        nxt = 8'h00;
        if (cur == 8'h00) begin
            nxt = 8'h01;
        end else begin
            nxt = {cur[6:0], lfsr_feedback(cur)};
        end
    end

endmodule

// File: rtl/mux_8_1_vector_sequencer.sv
// Clocked sweep of all 8 selects over NUM_ROUNDS data words, scoring the
// fabric mux output against d_out[s_out].
module mux_8_1_vector_sequencer
    import mux_8_1_seq_pkg::*;
#(
    parameter logic [7:0] DATA_PATTERN  = 8'h55,
    parameter int         NUM_ROUNDS    = 4,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         CNT_W         = 16
) (
    input  logic                          clock0,
    input  logic                          global_resetn,
    mux_8_1_vector_sequencer_if.master    bus
);

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       LAST_ROUND  = 8'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    seq_state_e              state_r;
    logic [7:0]              d_r;
    logic [2:0]              s_r;
    logic [7:0]              round_r;
    logic [7:0]              timer_r;
    logic [CNT_W-1:0]        pass_r;
    logic [CNT_W-1:0]        fail_r;
    logic [FIRST_FAIL_W-1:0] first_fail_r;
    logic [7:0]              lfsr_next_s;
    logic                    sample_ok_s;

    mux_8_1_lfsr8 u_lfsr (
        .cur (d_r),
        .nxt (lfsr_next_s)
    );

    assign sample_ok_s = (bus.mux_out == d_r[s_r]);

    // Sequencer FSM: vector drive, settle timing, sampling and scoring.
    always_ff @(posedge clock0 or negedge global_resetn) begin
        if (!global_resetn) begin
            state_r      <= ST_IDLE;
            d_r          <= 8'h00;
            s_r          <= 3'd0;
            round_r      <= 8'd0;
            timer_r      <= 8'd0;
            pass_r       <= {CNT_W{1'b0}};
            fail_r       <= {CNT_W{1'b0}};
            first_fail_r <= {FIRST_FAIL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        d_r          <= DATA_PATTERN;
                        s_r          <= 3'd0;
                        round_r      <= 8'd0;
                        pass_r       <= {CNT_W{1'b0}};
                        fail_r       <= {CNT_W{1'b0}};
                        first_fail_r <= {FIRST_FAIL_W{1'b0}};
                        state_r      <= ST_DRIVE;
                    end else begin
                        state_r      <= state_r;
                    end
                end
                ST_DRIVE: begin
                    timer_r <= SETTLE_LOAD;
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (timer_r == 8'd0) begin
                        state_r <= ST_CHECK;
                    end else begin
                        timer_r <= timer_r - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (sample_ok_s) begin
                        if (pass_r != CNT_MAX) begin
                            pass_r <= pass_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        // Counters clear at start, so zero fails means this is the first.
                        if (fail_r == {CNT_W{1'b0}}) begin
                            first_fail_r <= {round_r, s_r};
                        end
                        if (fail_r != CNT_MAX) begin
                            fail_r <= fail_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    if (s_r != 3'd7) begin
                        s_r     <= s_r + 3'd1;
                        state_r <= ST_DRIVE;
                    end else if (round_r < LAST_ROUND) begin
                        d_r     <= lfsr_next_s;
                        round_r <= round_r + 8'd1;
                        s_r     <= 3'd0;
                        state_r <= ST_DRIVE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.d_out      = d_r;
    assign bus.s_out      = s_r;
    assign bus.pass_count = pass_r;
    assign bus.fail_count = fail_r;
    assign bus.first_fail = first_fail_r;
    assign bus.busy       = (state_r == ST_DRIVE) || (state_r == ST_SETTLE) || (state_r == ST_CHECK);
    assign bus.done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_mux_8_1_vector_sequencer.sv
// Directed bench for mux_8_1_vector_sequencer: four parameterisations with
// ideal, stuck-0 and inverting fabric models.
module tb_mux_8_1_vector_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] start_s;
    wire  [3:0] busy_s;
    wire  [3:0] done_s;
    wire  [7:0] d_mon [4];

    int n_checks;
    int n_fail;

    mux_8_1_vector_sequencer_if #(.CNT_W(16)) bus0 ();
    mux_8_1_vector_sequencer_if #(.CNT_W(16)) bus1 ();
    mux_8_1_vector_sequencer_if #(.CNT_W(16)) bus2 ();
    mux_8_1_vector_sequencer_if #(.CNT_W(16)) bus3 ();

    // Instance 0: defaults, ideal fabric.
    mux_8_1_vector_sequencer u_dut0 (.clock0(clk), .global_resetn(rst_n), .bus(bus0));
    // Instance 1: one round, fabric output stuck at 0.
    mux_8_1_vector_sequencer #(.NUM_ROUNDS(1)) u_dut1 (.clock0(clk), .global_resetn(rst_n), .bus(bus1));
    // Instance 2: two rounds, inverting fabric.
    mux_8_1_vector_sequencer #(.NUM_ROUNDS(2)) u_dut2 (.clock0(clk), .global_resetn(rst_n), .bus(bus2));
    // Instance 3: zero data pattern, two rounds, ideal fabric.
    mux_8_1_vector_sequencer #(.DATA_PATTERN(8'h00), .NUM_ROUNDS(2)) u_dut3 (.clock0(clk), .global_resetn(rst_n), .bus(bus3));

    assign bus0.start   = start_s[0];
    assign bus1.start   = start_s[1];
    assign bus2.start   = start_s[2];
    assign bus3.start   = start_s[3];
    assign bus0.mux_out = bus0.d_out[bus0.s_out];
    assign bus1.mux_out = 1'b0;
    assign bus2.mux_out = ~bus2.d_out[bus2.s_out];
    assign bus3.mux_out = bus3.d_out[bus3.s_out];

    assign busy_s = {bus3.busy, bus2.busy, bus1.busy, bus0.busy};
    assign done_s = {bus3.done, bus2.done, bus1.done, bus0.done};
    assign d_mon[0] = bus0.d_out;
    assign d_mon[1] = bus1.d_out;
    assign d_mon[2] = bus2.d_out;
    assign d_mon[3] = bus3.d_out;

    // Free-running fabric clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance idx, optionally re-pulse start at cycle inject_at,
    // snapshot d_out at cycle probe_at, and return cycles from start edge to done.
    task automatic run_seq(input int idx, input int inject_at, input int probe_at,
                           output int cycles, output logic [7:0] probe_d);
        int cnt;
        probe_d = 8'h00;
        start_s[idx] = 1'b1;
        @(negedge clk);
        start_s[idx] = 1'b0;
        cnt = 1;
        check_eq("busy_after_start", {31'd0, busy_s[idx]}, 32'd1);
        check_eq("done_after_start", {31'd0, done_s[idx]}, 32'd0);
        while (done_s[idx] !== 1'b1 && cnt < 2000) begin
            if (cnt == probe_at) probe_d = d_mon[idx];
            start_s[idx] = (cnt == inject_at);
            @(negedge clk);
            cnt++;
        end
        start_s[idx] = 1'b0;
        check_eq("done_reached", {31'd0, done_s[idx]}, 32'd1);
        check_eq("busy_at_done", {31'd0, busy_s[idx]}, 32'd0);
        cycles = cnt - 1;
    endtask

    initial begin
        int         cyc;
        logic [7:0] pd;
        n_checks = 0;
        n_fail   = 0;
        start_s  = 4'b0000;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_eq("rst_busy",  {31'd0, bus0.busy}, 32'd0);
        check_eq("rst_done",  {31'd0, bus0.done}, 32'd0);
        check_eq("rst_d_out", {24'd0, bus0.d_out}, 32'd0);
        check_eq("rst_s_out", {29'd0, bus0.s_out}, 32'd0);
        check_eq("rst_pass",  {16'd0, bus0.pass_count}, 32'd0);
        check_eq("rst_fail",  {16'd0, bus0.fail_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ideal fabric, default parameters.
        run_seq(0, -1, -1, cyc, pd);
        check_eq("t1_cycles", cyc, 32'd192);
        check_eq("t1_pass", {16'd0, bus0.pass_count}, 32'd32);
        check_eq("t1_fail", {16'd0, bus0.fail_count}, 32'd0);

        // 2: stuck-0 fabric with pattern 0x55 fails on sel 0,2,4,6.
        run_seq(1, -1, -1, cyc, pd);
        check_eq("t2_cycles", cyc, 32'd48);
        check_eq("t2_pass", {16'd0, bus1.pass_count}, 32'd4);
        check_eq("t2_fail", {16'd0, bus1.fail_count}, 32'd4);
        check_eq("t2_first_fail", {21'd0, bus1.first_fail}, 32'h000);

        // 3: inverting fabric fails every vector; lfsr(0x55) = {1010101, 0^0^1^0} = 0xAB.
        run_seq(2, -1, 50, cyc, pd);
        check_eq("t3_cycles", cyc, 32'd96);
        check_eq("t3_round1_d", {24'd0, pd}, 32'h0AB);
        check_eq("t3_pass", {16'd0, bus2.pass_count}, 32'd0);
        check_eq("t3_fail", {16'd0, bus2.fail_count}, 32'd16);
        check_eq("t3_first_fail", {21'd0, bus2.first_fail}, 32'h000);

        // 4: all-zero pattern escapes to 0x01 in round 1.
        run_seq(3, -1, 50, cyc, pd);
        check_eq("t4_round1_d", {24'd0, pd}, 32'h001);
        check_eq("t4_pass", {16'd0, bus3.pass_count}, 32'd16);
        check_eq("t4_fail", {16'd0, bus3.fail_count}, 32'd0);

        // 5: restart from DONE, extra start at cycle 10 is ignored.
        run_seq(0, 10, -1, cyc, pd);
        check_eq("t5_cycles", cyc, 32'd192);
        check_eq("t5_pass", {16'd0, bus0.pass_count}, 32'd32);

        // 6: reset asserted in SETTLE of vector 3 aborts the run.
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("t6_pass_before", {16'd0, bus0.pass_count}, 32'd3);
        check_eq("t6_sel_before", {29'd0, bus0.s_out}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", {31'd0, bus0.busy}, 32'd0);
        check_eq("t6_d_out", {24'd0, bus0.d_out}, 32'd0);
        check_eq("t6_pass", {16'd0, bus0.pass_count}, 32'd0);
        check_eq("t6_done", {31'd0, bus0.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t6_idle_busy", {31'd0, bus0.busy}, 32'd0);
        run_seq(0, -1, -1, cyc, pd);
        check_eq("t6_cycles", cyc, 32'd192);
        check_eq("t6_rerun_pass", {16'd0, bus0.pass_count}, 32'd32);
        check_eq("t6_rerun_fail", {16'd0, bus0.fail_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
